// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the 2-read/1-write operand register file.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address decode, r0 masking and same-cycle write bypass.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               rd_addr,
    input  logic                            wr_en,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [ADDR_W-1:0]               addr,
    output logic [DATA_W-1:0]               data
);

    always_comb begin
        data = '0;
        if (addr != ADDR_W'(ZERO_REG)) begin
            // addr is non-zero here, so a match also implies rd_addr is non-zero
            if (wr_en && (addr == rd_addr)) begin
                data = wr_data;
            end else begin
                data = regs[addr];
            end
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Operand register file: two combinational read ports with write bypass, one synchronous
// write port, hardwired-zero r0 and a saturating committed-write counter.
module reg_file_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [15:0]       wr_count
);

    if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_num_regs
        $error("NUM_REGS must equal 2**ADDR_W");
    end

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [15:0]                     wr_count_q;
    logic                            wr_fire;
    logic                            fwd_en;

    assign wr_fire = wr_en && (rd_addr != ADDR_W'(ZERO_REG));
    // No bypass while in reset so both ports read zero
    assign fwd_en  = wr_en && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            wr_count_q <= '0;
        end else if (wr_fire) begin
            regs_q[rd_addr] <= wr_data;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign wr_count = wr_count_q;

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_a (
        .regs    (regs_q),
        .rd_addr (rd_addr),
        .wr_en   (fwd_en),
        .wr_data (wr_data),
        .addr    (rs_addr),
        .data    (rs_data)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_b (
        .regs    (regs_q),
        .rd_addr (rd_addr),
        .wr_en   (fwd_en),
        .wr_data (wr_data),
        .addr    (rt_addr),
        .data    (rt_data)
    );

    wr_en_known: assert property (@(posedge clk) disable iff (!rst_n) wr_en === 1'b1 || wr_en === 1'b0)
        else $error("wr_en unknown at clock edge");

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: vector table plus hand-written reset, sweep and saturation sequences.
module tb_reg_file_2r1w;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs_addr, rt_addr, rd_addr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rs_data, rt_data;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    reg_file_2r1w #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_count (wr_count)
    );

    typedef struct {
        bit [127:0]  tag;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        bit [127:0]    tag;
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [DW-1:0] exp_rs;
        logic [DW-1:0] exp_rt;
        logic [15:0]   exp_cnt;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input bit [127:0] tag, input bit [31:0] field,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %0s.%0s actual=%h required=%h", tag, field, act, req);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        wr_en   = we;
        rd_addr = rd;
        wr_data = wd;
        rs_addr = rs;
        rt_addr = rt;
    endtask

    task automatic expect_out(input bit [127:0] tag, input logic [DW-1:0] ers,
                              input logic [DW-1:0] ert, input logic [15:0] ecnt);
        exp_t e;
        e.tag = tag;
        e.rs  = ers;
        e.rt  = ert;
        e.cnt = ecnt;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard actual=empty required=entry");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "rs", rs_data, e.rs);
            cmp(e.tag, "rt", rt_data, e.rt);
            cmp(e.tag, "cnt", {16'h0, wr_count}, {16'h0, e.cnt});
        end
    endtask

    vec_t          vecs[12];
    logic [DW-1:0] model[NR];

    initial begin
        // Expected outputs are the pre-edge values; cnt counts writes committed at earlier edges
        vecs[0]  = '{"reset_state", 1'b0, 5'd0, 32'h0,        5'd0, 5'd31, 32'h0,        32'h0,        16'd0};
        vecs[1]  = '{"wr_r3_fwd",   1'b1, 5'd3, 32'h0000FFFF, 5'd3, 5'd4,  32'h0000FFFF, 32'h0,        16'd0};
        vecs[2]  = '{"wr_r4_fwd",   1'b1, 5'd4, 32'hFFFF0000, 5'd3, 5'd4,  32'h0000FFFF, 32'hFFFF0000, 16'd1};
        vecs[3]  = '{"rd_r3_r4",    1'b0, 5'd4, 32'h0,        5'd3, 5'd4,  32'h0000FFFF, 32'hFFFF0000, 16'd2};
        vecs[4]  = '{"zero_pre",    1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0,  32'h0,        32'h0,        16'd2};
        vecs[5]  = '{"zero_post",   1'b0, 5'd0, 32'h12345678, 5'd0, 5'd3,  32'h0,        32'h0000FFFF, 16'd2};
        vecs[6]  = '{"wr_r7_a5",    1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 16'd2};
        vecs[7]  = '{"fwd_r7_5a",   1'b1, 5'd7, 32'h5A5A5A5A, 5'd7, 5'd7,  32'h5A5A5A5A, 32'h5A5A5A5A, 16'd3};
        vecs[8]  = '{"post_r7",     1'b0, 5'd7, 32'h0,        5'd7, 5'd7,  32'h5A5A5A5A, 32'h5A5A5A5A, 16'd4};
        vecs[9]  = '{"no_fwd_dis",  1'b0, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd3,  32'h5A5A5A5A, 32'h0000FFFF, 16'd4};
        vecs[10] = '{"no_fwd_addr", 1'b1, 5'd8, 32'h11111111, 5'd7, 5'd9,  32'h5A5A5A5A, 32'h0,        16'd4};
        vecs[11] = '{"rd_r8",       1'b0, 5'd0, 32'h0,        5'd8, 5'd8,  32'h11111111, 32'h11111111, 16'd5};

        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].rs, vecs[i].rt);
            expect_out(vecs[i].tag, vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_cnt);
            #4;
            check_out();
        end

        // Async reset mid-cycle after writing r5
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        expect_out("wr_r5", 32'hDEADBEEF, 32'hDEADBEEF, 16'd5);
        #4;
        check_out();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        expect_out("rd_r5", 32'hDEADBEEF, 32'hDEADBEEF, 16'd6);
        #2;
        check_out();
        rst_n = 1'b0;
        expect_out("rst_async", 32'h0, 32'h0, 16'd0);
        #1;
        check_out();
        drive(1'b1, 5'd6, 32'hCAFEF00D, 5'd6, 5'd6);
        expect_out("rst_no_fwd", 32'h0, 32'h0, 16'd0);
        #1;
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd6, 32'hCAFEF00D, 5'd6, 5'd5);
        expect_out("rst_discard", 32'h0, 32'h0, 16'd0);
        #4;
        check_out();

        // Full sweep of every register
        model[0] = '0;
        for (int i = 1; i < 32; i++) begin
            model[i] = i * 32'h01010101;
            @(negedge clk);
            drive(1'b1, AW'(i), model[i], AW'(i), 5'd0);
            expect_out("sweep_wr", model[i], 32'h0, 16'(i - 1));
            #4;
            check_out();
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, AW'(i), AW'(31 - i));
            expect_out("sweep_rd", model[i], model[31 - i], 16'd31);
            #4;
            check_out();
        end

        // Saturating write counter
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clk);
            drive(1'b1, 5'd1, 32'(k), 5'd2, 5'd2);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
        expect_out("saturate", 32'd65540, 32'd65540, 16'hFFFF);
        #4;
        check_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
